// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the program-counter sequencer.
// Used by pc_seq and pc_next_mux.
package pc_seq_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        EXC    = 1'b1
    } pc_state_t;

    localparam int unsigned RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int unsigned EXC_VECTOR_DEF   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select for pc_seq.
// PC_SEQ_MISALIGN_TRAP_EN turns unaligned jump/branch targets into an exception entry.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned          WIDTH      = 32,
    parameter int unsigned          STEP       = 4,
    parameter logic [WIDTH-1:0]     EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF)
) (
    input  pc_state_t           state,
    input  logic                en,
    input  logic                exc_req,
    input  logic                eret,
    input  logic                jump,
    input  logic [WIDTH-1:0]    jump_tgt,
    input  logic                branch_taken,
    input  logic [WIDTH-1:0]    branch_tgt,
    input  logic [WIDTH-1:0]    pc,
    input  logic [WIDTH-1:0]    epc,
    output logic [WIDTH-1:0]    next_pc,
    output logic                enter_exc,
    output logic                leave_exc
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    output logic                misalign_set
`endif
);

    logic [WIDTH-1:0] tgt;
    logic             tgt_sel;

    assign tgt     = jump ? jump_tgt : branch_tgt;
    assign tgt_sel = jump | branch_taken;

    always_comb begin
        next_pc   = pc;
        enter_exc = 1'b0;
        leave_exc = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        misalign_set = 1'b0;
`endif
        // EXC_REQ in NORMAL is the only event that bypasses the stall
        if (state == NORMAL && exc_req) begin
            next_pc   = EXC_VECTOR;
            enter_exc = 1'b1;
        end else if (en) begin
            if (state == EXC && eret) begin
                next_pc   = epc;
                leave_exc = 1'b1;
            end else if (tgt_sel) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                if (state == NORMAL && tgt[1:0] != 2'b00) begin
                    next_pc      = EXC_VECTOR;
                    enter_exc    = 1'b1;
                    misalign_set = 1'b1;
                end else begin
                    next_pc = tgt;
                end
`else
                next_pc = {tgt[WIDTH-1:2], 2'b00};
`endif
            end else begin
                next_pc = pc + WIDTH'(STEP);
            end
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential/branch/jump/exception PC with EPC save and ERET.
// Optional misalignment trap and MISALIGN output under PC_SEQ_MISALIGN_TRAP_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned          WIDTH        = 32,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [WIDTH-1:0]     EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
    parameter int unsigned          STEP         = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                EN,
    input  logic                BRANCH_TAKEN,
    input  logic [WIDTH-1:0]    BRANCH_TGT,
    input  logic                JUMP,
    input  logic [WIDTH-1:0]    JUMP_TGT,
    input  logic                EXC_REQ,
    input  logic                ERET,
    output logic [WIDTH-1:0]    PC_OUT,
    output logic [WIDTH-1:0]    PC_PLUS,
    output logic [WIDTH-1:0]    EPC_OUT,
    output logic                IN_EXC
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    output logic                MISALIGN
`endif
);

    pc_state_t          state_q;
    pc_state_t          state_d;
    logic [WIDTH-1:0]   next_pc;
    logic               enter_exc;
    logic               leave_exc;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic               misalign_set;
`endif

    pc_next_mux #(
        .WIDTH      (WIDTH),
        .STEP       (STEP),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .state        (state_q),
        .en           (EN),
        .exc_req      (EXC_REQ),
        .eret         (ERET),
        .jump         (JUMP),
        .jump_tgt     (JUMP_TGT),
        .branch_taken (BRANCH_TAKEN),
        .branch_tgt   (BRANCH_TGT),
        .pc           (PC_OUT),
        .epc          (EPC_OUT),
        .next_pc      (next_pc),
        .enter_exc    (enter_exc),
        .leave_exc    (leave_exc)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        ,
        .misalign_set (misalign_set)
`endif
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= NORMAL;
            PC_OUT  <= RESET_VECTOR;
            EPC_OUT <= '0;
        end else begin
            state_q <= state_d;
            PC_OUT  <= next_pc;
            if (enter_exc)
                EPC_OUT <= PC_OUT;
        end
    end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            MISALIGN <= 1'b0;
        else if (misalign_set)
            MISALIGN <= 1'b1;
        else if (leave_exc)
            MISALIGN <= 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL:  if (enter_exc) state_d = EXC;
            EXC:     if (leave_exc) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_comb begin
        IN_EXC = (state_q == EXC);
    end

    assign PC_PLUS = PC_OUT + WIDTH'(STEP);

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: directed scenarios then random traffic against a behavioural model.
// Honours PC_SEQ_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_seq;

    logic        CLK = 1'b0;
    logic        RESET, EN, BRANCH_TAKEN, JUMP, EXC_REQ, ERET;
    logic [31:0] BRANCH_TGT, JUMP_TGT;
    logic [31:0] PC_OUT, PC_PLUS, EPC_OUT;
    logic        IN_EXC;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        MISALIGN;
`endif

    always #5 CLK = ~CLK;

    pc_seq dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .EN           (EN),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TGT   (BRANCH_TGT),
        .JUMP         (JUMP),
        .JUMP_TGT     (JUMP_TGT),
        .EXC_REQ      (EXC_REQ),
        .ERET         (ERET),
        .PC_OUT       (PC_OUT),
        .PC_PLUS      (PC_PLUS),
        .EPC_OUT      (EPC_OUT),
        .IN_EXC       (IN_EXC)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        ,
        .MISALIGN     (MISALIGN)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        exc;
        logic        mis;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_exc, m_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%08h expected 'h%08h", nm, act, exp);
        end
    endtask

    // monitor: every cycle the registered outputs present a new value
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, ".pc"},      PC_OUT,          e.pc);
                chk({e.name, ".pc_plus"}, PC_PLUS,         e.pc + 32'd4);
                chk({e.name, ".epc"},     EPC_OUT,         e.epc);
                chk({e.name, ".in_exc"},  32'(IN_EXC),     32'(e.exc));
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                chk({e.name, ".misalign"}, 32'(MISALIGN),  32'(e.mis));
`endif
            end
        end
    end

    function automatic void model_step(input logic rst, en, exc, eret, j,
                                       input logic [31:0] jt, input logic b,
                                       input logic [31:0] bt);
        logic [31:0] t;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_exc = 1'b0; m_mis = 1'b0;
        end else if (!m_exc && exc) begin
            m_epc = m_pc; m_pc = 32'h80; m_exc = 1'b1;
        end else if (en) begin
            if (m_exc && eret) begin
                m_pc = m_epc; m_exc = 1'b0; m_mis = 1'b0;
            end else if (j || b) begin
                t = j ? jt : bt;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                if (!m_exc && (t % 4) != 0) begin
                    m_epc = m_pc; m_pc = 32'h80; m_exc = 1'b1; m_mis = 1'b1;
                end else begin
                    m_pc = t;
                end
`else
                m_pc = t - (t % 4);
`endif
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic cyc(input logic rst, en, exc, eret, j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input string nm);
        exp_t e;
        RESET = rst; EN = en; EXC_REQ = exc; ERET = eret;
        JUMP = j; JUMP_TGT = jt; BRANCH_TAKEN = b; BRANCH_TGT = bt;
        model_step(rst, en, exc, eret, j, jt, b, bt);
        e.pc = m_pc; e.epc = m_epc; e.exc = m_exc; e.mis = m_mis; e.name = nm;
        q.push_back(e);
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] jt, bt;
        // reset and sequential fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, "seq");
        // stall ignores jump
        cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset2");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "seq2");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "seq2");
        cyc(0, 0, 0, 0, 1, 32'h100, 0, 0, "stall_jump");
        cyc(0, 0, 0, 0, 1, 32'h100, 0, 0, "stall_jump");
        cyc(0, 1, 0, 0, 1, 32'h100, 0, 0, "jump");
        // exception entry overriding stall, no nesting, ERET
        cyc(0, 1, 0, 0, 1, 32'h40, 0, 0, "jump40");
        cyc(0, 0, 1, 0, 0, 0, 0, 0, "exc_entry");
        cyc(0, 1, 1, 0, 0, 0, 0, 0, "exc_nested");
        cyc(0, 1, 0, 1, 0, 0, 0, 0, "eret");
        cyc(0, 1, 0, 1, 0, 0, 0, 0, "eret_in_normal");
        // jump beats branch, wrap-around
        cyc(0, 1, 0, 0, 1, 32'h200, 1, 32'h300, "jump_vs_branch");
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h300, "branch");
        cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, "jump_top");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "wrap");
        // misaligned target
        cyc(0, 1, 0, 0, 1, 32'h10, 0, 0, "jump10");
        cyc(0, 1, 0, 0, 1, 32'h102, 0, 0, "misalign_jump");
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h203, "misalign_branch");
        cyc(0, 1, 0, 1, 0, 0, 0, 0, "eret2");
        // reset abandons a handler
        cyc(0, 0, 1, 0, 0, 0, 0, 0, "exc_entry2");
        cyc(1, 1, 1, 1, 1, 32'h500, 0, 0, "reset_in_exc");
        // random traffic
        for (int i = 0; i < 600; i++) begin
            jt = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            bt = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, jt, $urandom_range(0, 3) == 0, bt, "rand");
        end
        RESET = 1'b0; EN = 1'b0; EXC_REQ = 1'b0; ERET = 1'b0; JUMP = 1'b0; BRANCH_TAKEN = 1'b0;
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge CLK);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter WIDTH, default 32: PC, target and EPC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 'h80: PC value loaded on exception entry.
REQ-004 Parameter STEP, default 4: sequential increment in bytes.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-007 EN  in  1  update enable; 0 means stall and PC holds.
REQ-008 BRANCH_TAKEN  in  1  load BRANCH_TGT.
REQ-009 BRANCH_TGT  in  WIDTH  branch target.
REQ-010 JUMP  in  1  load JUMP_TGT.
REQ-011 JUMP_TGT  in  WIDTH  jump or jump-register target.
REQ-012 EXC_REQ  in  1  exception request.
REQ-013 ERET  in  1  return from exception.
REQ-014 PC_OUT  out  WIDTH  current PC, registered.
REQ-015 PC_PLUS  out  WIDTH  PC_OUT+STEP, combinational.
REQ-016 EPC_OUT  out  WIDTH  saved exception PC, registered.
REQ-017 IN_EXC  out  1  high while in state EXC.

Function
REQ-018 The block SHALL have two states: NORMAL and EXC. IN_EXC SHALL equal (state==EXC).
REQ-019 Next-PC priority, highest first, SHALL be: EXC_REQ (NORMAL only), ERET (EXC only), JUMP, BRANCH_TAKEN, sequential.
REQ-020 EXC_REQ in NORMAL SHALL override EN=0. On the next edge: EPC<=PC_OUT, PC<=EXC_VECTOR, state<=EXC.
REQ-021 EXC_REQ in EXC SHALL be ignored (no nesting). EPC SHALL hold, and the PC SHALL follow the remaining priority.
REQ-022 ERET with EN=1 in EXC SHALL set PC<=EPC and state<=NORMAL. ERET in NORMAL SHALL be ignored.
REQ-023 With EN=0 and no EXC_REQ taken, PC, EPC and state SHALL hold regardless of JUMP, BRANCH_TAKEN and ERET.
REQ-024 With EN=1 and no higher-priority event, the PC SHALL update as follows:
- JUMP: PC<=JUMP_TGT.
- BRANCH_TAKEN: PC<=BRANCH_TGT.
- otherwise: PC<=PC_OUT+STEP.
REQ-025 JUMP and BRANCH_TAKEN high together SHALL select JUMP.
REQ-026 All PC arithmetic SHALL be modulo 2^WIDTH. Example: PC_OUT=2^WIDTH-4 increments to 0. PC_PLUS wraps in the same way.
REQ-027 Every PC update SHALL have a latency of one cycle; PC_OUT changes only on a rising CLK edge.
REQ-028 EPC SHALL change only on exception entry, including misalign entry per REQ-033.

Reset
REQ-029 RESET SHALL override all other inputs, including EXC_REQ and EN.
REQ-030 Reset values SHALL be: PC_OUT=RESET_VECTOR, EPC_OUT=0, state=NORMAL (IN_EXC=0), MISALIGN=0.
REQ-031 RESET asserted mid-operation in EXC SHALL abandon the handler and return to NORMAL at RESET_VECTOR on the same edge.

Configuration
REQ-032 Macro PC_SEQ_MISALIGN_TRAP_EN SHALL enable the misalignment trap.
REQ-033 With the macro defined:
- Output MISALIGN (out, 1, registered) SHALL be present.
- Condition: state NORMAL, EN=1, and a selected JUMP or BRANCH target with bits [1:0] nonzero.
- On that condition the block SHALL take an exception entry: EPC<=PC_OUT, PC<=EXC_VECTOR, state<=EXC.
- MISALIGN SHALL be set to 1 on that entry and cleared on ERET exit or reset.
REQ-034 With the macro undefined:
- There SHALL be no MISALIGN port.
- Selected JUMP and BRANCH targets SHALL load with bits [1:0] forced to 0.

Structure
REQ-035 A shared package SHALL hold the state enum (NORMAL, EXC) and the default vector constants RESET_VECTOR_DEF and EXC_VECTOR_DEF.
REQ-036 Sub-module pc_next_mux SHALL hold the combinational next-PC priority select. The registers and FSM SHALL stay in pc_seq.

Verification
REQ-037 Reset then 3 cycles of EN=1 -> PC_OUT sequence 0, 4, 8, 12; IN_EXC=0; EPC_OUT=0.
REQ-038 At PC=8, EN=0 with JUMP=1 and JUMP_TGT='h100 for 2 cycles -> PC stays 8; then EN=1 -> PC='h100.
REQ-039 At PC='h40, EXC_REQ=1 with EN=0 -> next PC='h80, EPC_OUT='h40, IN_EXC=1.
REQ-040 Second EXC_REQ in EXC -> EPC stays 'h40. Then ERET=1 -> PC='h40, IN_EXC=0.
REQ-041 JUMP and BRANCH_TAKEN together (JUMP_TGT='h200, BRANCH_TGT='h300) -> PC='h200. With PC='hFFFFFFFC and EN=1 -> PC=0.
REQ-042 Macro on: JUMP_TGT='h102 at PC='h10 -> PC='h80, EPC='h10, MISALIGN=1. Macro off: same stimulus -> PC='h100.
